// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch responder.
// The state encoding and word geometry live here so controller-side code can reuse them.
package fetch_unit_pkg;

   localparam int unsigned WORD        = 16;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned FETCH_BYTES = 4;

   typedef enum logic [2:0] {
      FETCH_IDLE  = 3'd0,
      FETCH_ISSUE = 3'd1,
      FETCH_WAIT  = 3'd2,
      FETCH_NEXT  = 3'd3,
      FETCH_DONE  = 3'd4
   } fetch_state_e;

   // Little-endian assembly of two consecutive bytes into one word.
   function automatic logic [WORD-1:0] le_word(input logic [BYTE_W-1:0] lo,
                                               input logic [BYTE_W-1:0] hi);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch responder: reads instruction + immediate (4 bytes) over a
// byte-wide fixed-latency memory port and returns both words with a done pulse.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              busy,
   output logic              done,
   output logic [WORD-1:0]   instr,
   output logic [WORD-1:0]   imm,
   output logic              misalign,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [BYTE_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
   localparam int unsigned K_W   = $clog2(FETCH_BYTES);

   fetch_state_e                         state;
   logic [ADDR_W-1:0]                    base;
   logic [K_W-1:0]                       k;
   logic [K_W-1:0]                       k_next;
   logic [CNT_W-1:0]                     cnt;
   logic [FETCH_BYTES-1:0][BYTE_W-1:0]   slots;

   assign k_next = k + 1'b1;

   // Outputs are registered; mem_re is set on entry to ISSUE, done is raised
   // in the second cycle of DONE so the DONE state covers the done cycle too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FETCH_IDLE;
         base     <= '0;
         k        <= '0;
         cnt      <= '0;
         slots    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         misalign <= 1'b0;
         instr    <= '0;
         imm      <= '0;
         mem_re   <= 1'b0;
         mem_addr <= '0;
      end else begin
         mem_re <= 1'b0;
         case (state)
            FETCH_IDLE: begin
               if (fetch) begin
                  base     <= fetch_addr;
                  k        <= '0;
                  busy     <= 1'b1;
                  misalign <= 1'b0;
                  if (fetch_addr[0]) begin
                     state <= FETCH_DONE;
                  end else begin
                     mem_re   <= 1'b1;
                     mem_addr <= fetch_addr;
                     state    <= FETCH_ISSUE;
                  end
               end
            end
            FETCH_ISSUE: begin
               cnt   <= CNT_W'(MEM_LAT);
               state <= FETCH_WAIT;
            end
            FETCH_WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  slots[k] <= mem_rdata;
                  state    <= FETCH_NEXT;
               end
            end
            FETCH_NEXT: begin
               if (k == K_W'(FETCH_BYTES - 1)) begin
                  state <= FETCH_DONE;
               end else begin
                  k        <= k_next;
                  mem_re   <= 1'b1;
                  mem_addr <= base + ADDR_W'(k_next);
                  state    <= FETCH_ISSUE;
               end
            end
            FETCH_DONE: begin
               if (!done) begin
                  done     <= 1'b1;
                  misalign <= base[0];
                  instr    <= base[0] ? '0 : le_word(slots[0], slots[1]);
                  imm      <= base[0] ? '0 : le_word(slots[2], slots[3]);
               end else begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= FETCH_IDLE;
               end
            end
            default: state <= FETCH_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit: two instances (latency 1 and 3)
// against a byte-array memory and a transaction-level expectation model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch      [2];
   logic [15:0] fetch_addr [2];
   logic        busy       [2];
   logic        done       [2];
   logic [15:0] instr      [2];
   logic [15:0] imm        [2];
   logic        misalign   [2];
   logic        mem_re     [2];
   logic [15:0] mem_addr   [2];
   logic [7:0]  mem_rdata  [2];

   logic [7:0]  mem [0:65535];
   int          re_cnt [2];
   logic [15:0] re_log [2][8];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_u
      localparam int unsigned LAT = (g == 0) ? 1 : 3;
      logic [7:0] pipe [LAT];

      fetch_unit #(.ADDR_W(16), .MEM_LAT(LAT)) dut (
         .clk       (clk),
         .rst       (rst),
         .fetch     (fetch[g]),
         .fetch_addr(fetch_addr[g]),
         .busy      (busy[g]),
         .done      (done[g]),
         .instr     (instr[g]),
         .imm       (imm[g]),
         .misalign  (misalign[g]),
         .mem_re    (mem_re[g]),
         .mem_addr  (mem_addr[g]),
         .mem_rdata (mem_rdata[g])
      );

      // Memory with LAT register stages; data is only present for one cycle.
      always @(posedge clk) begin
         pipe[0] <= mem_re[g] ? mem[mem_addr[g]] : 8'h00;
         for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
         if (mem_re[g]) begin
            re_log[g][re_cnt[g] % 8] <= mem_addr[g];
            re_cnt[g] <= re_cnt[g] + 1;
         end
      end
      assign mem_rdata[g] = pipe[LAT-1];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input int u, input string tag);
      check({tag, "_busy"},  32'(busy[u]), 32'd0);
      check({tag, "_done"},  32'(done[u]), 32'd0);
      check({tag, "_re"},    32'(mem_re[u]), 32'd0);
      check({tag, "_addr"},  32'(mem_addr[u]), 32'd0);
      check({tag, "_instr"}, 32'(instr[u]), 32'd0);
      check({tag, "_imm"},   32'(imm[u]), 32'd0);
      check({tag, "_mis"},   32'(misalign[u]), 32'd0);
   endtask

   // One request end to end; extra=1 also pulses fetch at +3 and in the done cycle.
   task automatic run_fetch(input int u, input logic [15:0] a, input bit extra);
      int lat, exp_lat, exp_pulses, s, n, busy_bad, extra_done;
      bit seen;
      logic [15:0] exp_instr, exp_imm, ai;
      lat        = (u == 0) ? 1 : 3;
      exp_lat    = a[0] ? 1 : 4 * (lat + 2) + 1;
      exp_pulses = a[0] ? 0 : 4;
      exp_instr  = 16'h0;
      exp_imm    = 16'h0;
      if (!a[0]) begin
         exp_instr = {mem[a + 16'd1], mem[a]};
         exp_imm   = {mem[a + 16'd3], mem[a + 16'd2]};
      end
      s = re_cnt[u];
      fetch[u] = 1'b1;
      fetch_addr[u] = a;
      @(posedge clk); #1;
      fetch[u] = 1'b0;
      n = 0; seen = 0; busy_bad = 0;
      while (n < 100 && !seen) begin
         fetch[u] = (extra && n == 2);
         @(posedge clk); #1;
         n++;
         if (!busy[u]) busy_bad++;
         if (done[u]) seen = 1;
      end
      fetch[u] = 1'b0;
      check("latency", seen ? 32'(n) : 32'd999, 32'(exp_lat));
      check("busy_span", 32'(busy_bad), 32'd0);
      check("instr", 32'(instr[u]), 32'(exp_instr));
      check("imm", 32'(imm[u]), 32'(exp_imm));
      check("misalign", 32'(misalign[u]), 32'(a[0]));
      if (extra) fetch[u] = 1'b1;
      @(posedge clk); #1;
      fetch[u] = 1'b0;
      check("done_pulse", 32'(done[u]), 32'd0);
      check("busy_after", 32'(busy[u]), 32'd0);
      extra_done = 0;
      for (int i = 0; i < (extra ? 30 : 3); i++) begin
         @(posedge clk); #1;
         if (done[u] || busy[u]) extra_done++;
      end
      check("quiet_after", 32'(extra_done), 32'd0);
      check("re_pulses", 32'(re_cnt[u] - s), 32'(exp_pulses));
      if (!a[0]) begin
         for (int i = 0; i < 4; i++) begin
            ai = a + 16'(i);
            check("re_addr", 32'(re_log[u][(s + i) % 8]), 32'(ai));
         end
      end
   endtask

   task automatic fill(input logic [15:0] a, input logic [31:0] bytes);
      for (int i = 0; i < 4; i++) mem[a + 16'(i)] = bytes[8*i +: 8];
   endtask

   initial begin
      int nd;
      logic [15:0] a;
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         fetch[u] = 1'b0;
         fetch_addr[u] = 16'h0;
         re_cnt[u] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs(0, "rst0");
      check_idle_outputs(1, "rst1");
      rst = 1'b0;

      fill(16'h0010, 32'h5678_1234);
      run_fetch(0, 16'h0010, 0);
      run_fetch(1, 16'h0010, 0);

      fill(16'hFFFE, 32'hEF01_ABCD);
      run_fetch(0, 16'hFFFE, 0);
      run_fetch(1, 16'hFFFE, 0);

      run_fetch(0, 16'h0011, 0);
      run_fetch(0, 16'h0010, 0);
      run_fetch(1, 16'h0011, 0);

      run_fetch(0, 16'h0010, 1);

      // Reset in the middle of a request: nothing completes.
      fetch[0] = 1'b1;
      fetch_addr[0] = 16'h0010;
      @(posedge clk); #1;
      fetch[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1 check_idle_outputs(0, "midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (done[0] || busy[0]) nd++;
      end
      check("no_done_after_rst", 32'(nd), 32'd0);
      fill(16'h0020, 32'hCAFE_BEEF);
      run_fetch(0, 16'h0020, 0);

      for (int t = 0; t < 16; t++) begin
         a = 16'($urandom);
         if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
         if (t == 5) a = 16'hFFFD;
         fill(a, $urandom);
         run_fetch(int'($urandom_range(0, 1)), a, ($urandom_range(0, 4) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch responder: the memory-side end of the CPU controller's fetch trigger. It accepts a one-cycle fetch request with a byte address and reads the instruction word and the following immediate word over an 8-bit memory read port with fixed latency. It assembles both 16-bit words little-endian and returns them with a one-cycle done pulse. It sits between the CPU stage controller (PC, fetch trigger) and the byte-wide program memory.

Parameters:
WORD, 16, instruction/immediate word width; equals `WORD from fmt.v
ADDR_W, 16, byte address width; all address arithmetic is modulo 2^ADDR_W
MEM_LAT, 1, cycles from the edge sampling mem_re=1 to mem_rdata valid (>=1)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-high reset
fetch  input  1  fetch request; sampled only in IDLE
fetch_addr  input  ADDR_W  byte address of the instruction; must be even
busy  output  1  high from the cycle after acceptance through the done cycle
done  output  1  one-cycle pulse; instr/imm/misalign valid
instr  output  WORD  instruction word = {mem[a+1], mem[a]}
imm  output  WORD  immediate word = {mem[a+3], mem[a+2]}
misalign  output  1  set with done when fetch_addr[0]=1
mem_re  output  1  byte read strobe, one cycle per byte
mem_addr  output  ADDR_W  byte read address
mem_rdata  input  8  read data, valid MEM_LAT cycles after mem_re is sampled

Behaviour:
- Reset (async assert, any state): state=IDLE; busy, done, misalign, mem_re = 0; instr, imm, mem_addr = 0; byte counter and latency counter = 0. An in-flight fetch is abandoned and produces no done.
- States: IDLE, ISSUE, WAIT, NEXT, DONE.
- IDLE: on fetch=1, latch base = fetch_addr and clear byte index k=0. Odd address -> DONE directly, no memory reads. Even address -> ISSUE.
- ISSUE (1 cycle): mem_re=1, mem_addr = base+k (mod 2^ADDR_W); load latency counter = MEM_LAT -> WAIT.
- WAIT: decrement counter; when it reaches 0, capture mem_rdata into byte slot k -> NEXT.
- NEXT: if k==3 -> DONE, else k=k+1 -> ISSUE.
- Each byte costs MEM_LAT+2 cycles. done is high exactly 4*(MEM_LAT+2)+1 cycles after the edge that sampled fetch; with MEM_LAT=1, that is 13 cycles.
- DONE (1 cycle): done=1; instr/imm driven from the assembled slots -> IDLE.
- Misaligned path: done one cycle after acceptance; misalign=1, instr=0, imm=0, mem_re never asserted.
- misalign clears on the next accepted fetch. instr/imm hold their values until the next DONE.
- mem_re is 0 in all states except ISSUE. mem_addr holds its last value outside ISSUE.
- fetch while busy (including the DONE cycle) is ignored and not queued.
- Wrap-around: base=0xFFFE reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset deasserted mid-request: the first fetch is sampled at the first posedge with rst=0.

Decomposition:
- fmt.v (shared): WORD; new FETCH_IDLE/ISSUE/WAIT/NEXT/DONE state encodings (3-bit); FETCH_BYTES=4.
- Optional sub-module fetch_byte_seq: byte index plus latency counter, with issue/capture strobes. The FSM and assembly registers stay in fetch_unit.

Test Plan:
- mem[0x10..0x13]=34,12,78,56; fetch @0x0010, MEM_LAT=1 -> mem_re at addrs 0x10,0x11,0x12,0x13; done at +13 cycles; instr=0x1234, imm=0x5678, misalign=0.
- MEM_LAT=3, same data -> done at +21 cycles, same words; exactly 4 mem_re pulses.
- mem[0xFFFE]=0xCD, [0xFFFF]=0xAB, [0x0000]=0x01, [0x0001]=0xEF; fetch @0xFFFE -> instr=0xABCD, imm=0xEF01; mem_addr wraps to 0x0000.
- fetch @0x0011 -> done at +1 cycle, misalign=1, instr=imm=0, zero mem_re pulses; next fetch @0x0010 clears misalign.
- Second fetch pulse at +3 and at the done cycle of a fetch @0x0010 -> both ignored; exactly one done, 4 mem_re pulses.
- rst pulse at +5 of a fetch @0x0010 -> immediate IDLE, outputs 0, no done; a new fetch @0x0020 completes normally.
